// File: rtl/load_buffer.sv
// rtl/load_buffer.sv - in-order load queue: one outstanding memory read at a time, extends
// the returned data and broadcasts it on the load lane of the CDB; flush-safe handshake.
module load_buffer #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int RDY_SLACK = 2,
  parameter int ADDR_W    = 32,
  parameter int ROB_W     = 4,
  parameter int ID_W      = 32,
  parameter int OP_W      = 3,
  parameter logic [OP_W-1:0] OP_LB  = 3'd0,
  parameter logic [OP_W-1:0] OP_LH  = 3'd1,
  parameter logic [OP_W-1:0] OP_LW  = 3'd2,
  parameter logic [OP_W-1:0] OP_LBU = 3'd3,
  parameter logic [OP_W-1:0] OP_LHU = 3'd4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  output logic              lbuffer_rs_rdy_out,
  input  logic              addrunit_lbuffer_en_in,
  input  logic [ADDR_W-1:0] addrunit_lbuffer_addr_in,
  input  logic [ROB_W-1:0]  addrunit_lbuffer_dest_in,
  input  logic [OP_W-1:0]   addrunit_lbuffer_op_in,
  output logic              lbuffer_mem_en_out,
  output logic [ADDR_W-1:0] lbuffer_mem_addr_out,
  output logic [2:0]        lbuffer_mem_size_out,
  input  logic              mem_lbuffer_done_in,
  input  logic [ID_W-1:0]   mem_lbuffer_data_in,
  input  logic              rob_lbuffer_rst_in,
  output logic [ROB_W-1:0]  cdb_lbuffer_b_out,
  output logic [ID_W-1:0]   cdb_lbuffer_result_out,
  output logic              lbuffer_overflow_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [PTR_W:0] DEPTH_C = PTR_W'(0) + (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] SLACK_C = (PTR_W+1)'(RDY_SLACK);

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [ROB_W-1:0]  r_q_dest [DEPTH];
  logic [OP_W-1:0]   r_q_op   [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [0:0]        r_state;
  logic              r_squash;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [2:0]        r_mem_size;
  logic [ROB_W-1:0]  r_cdb_b;
  logic [ID_W-1:0]   r_cdb_result;
  logic              r_overflow;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W:0]    w_free;
  logic [2:0]        w_head_size;
  logic [ID_W-1:0]   w_ext;

  assign w_full = (r_count == DEPTH_C);
  assign w_free = DEPTH_C - r_count;
  assign w_push = addrunit_lbuffer_en_in && !w_full && !rob_lbuffer_rst_in;
  // A flush on the completing edge discards the result, so the head is not popped either.
  assign w_pop  = (r_state == S_WAIT) && mem_lbuffer_done_in && !r_squash && !rob_lbuffer_rst_in;

  assign lbuffer_rs_rdy_out     = (w_free >= SLACK_C);
  assign lbuffer_mem_en_out     = r_mem_en;
  assign lbuffer_mem_addr_out   = r_mem_addr;
  assign lbuffer_mem_size_out   = r_mem_size;
  assign cdb_lbuffer_b_out      = r_cdb_b;
  assign cdb_lbuffer_result_out = r_cdb_result;
  assign lbuffer_overflow_out   = r_overflow;

  always_comb begin
    w_head_size = 3'd4;
    if (r_q_op[r_head] == OP_LB || r_q_op[r_head] == OP_LBU) w_head_size = 3'd1;
    else if (r_q_op[r_head] == OP_LH || r_q_op[r_head] == OP_LHU) w_head_size = 3'd2;
  end

  always_comb begin
    w_ext = mem_lbuffer_data_in;
    if (r_q_op[r_head] == OP_LB)
      w_ext = {{(ID_W-8){mem_lbuffer_data_in[7]}}, mem_lbuffer_data_in[7:0]};
    else if (r_q_op[r_head] == OP_LBU)
      w_ext = {{(ID_W-8){1'b0}}, mem_lbuffer_data_in[7:0]};
    else if (r_q_op[r_head] == OP_LH)
      w_ext = {{(ID_W-16){mem_lbuffer_data_in[15]}}, mem_lbuffer_data_in[15:0]};
    else if (r_q_op[r_head] == OP_LHU)
      w_ext = {{(ID_W-16){1'b0}}, mem_lbuffer_data_in[15:0]};
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && w_push) begin
      r_q_addr[r_tail] <= addrunit_lbuffer_addr_in;
      r_q_dest[r_tail] <= addrunit_lbuffer_dest_in;
      r_q_op[r_tail]   <= addrunit_lbuffer_op_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_squash     <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_size   <= '0;
      r_cdb_b      <= '0;
      r_cdb_result <= '0;
      r_overflow   <= 1'b0;
    end else if (rdy_in) begin
      r_cdb_b <= '0;
      if (addrunit_lbuffer_en_in && w_full) r_overflow <= 1'b1;

      if (rob_lbuffer_rst_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
        r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      end

      case (r_state)
        S_IDLE: begin
          if (r_count != '0 && !r_squash && !rob_lbuffer_rst_in) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_q_addr[r_head];
            r_mem_size <= w_head_size;
            r_state    <= S_WAIT;
          end
        end
        default: begin
          // The request stays asserted through a flush; only done may end the handshake.
          if (mem_lbuffer_done_in) begin
            r_mem_en <= 1'b0;
            r_squash <= 1'b0;
            r_state  <= S_IDLE;
            if (w_pop) begin
              r_cdb_b      <= r_q_dest[r_head];
              r_cdb_result <= w_ext;
            end
          end else if (rob_lbuffer_rst_in) begin
            r_squash <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// tb/tb_load_buffer.sv - directed and randomized checks of load_buffer against a
// transaction-level queue model.
module tb_load_buffer;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rs_rdy;
  logic        en_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [3:0]  dest_in = '0;
  logic [2:0]  op_in = '0;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic        done = 1'b0;
  logic [31:0] data = '0;
  logic        flush = 1'b0;
  logic [3:0]  cdb_b;
  logic [31:0] cdb_res;
  logic        ovf;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  dest;
    logic [2:0]  op;
  } ld_t;

  ld_t         q[$];
  ld_t         m_req;
  bit          m_wait, m_sq, m_ovf;
  logic [3:0]  m_b;
  logic [31:0] m_res;

  load_buffer dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .lbuffer_rs_rdy_out(rs_rdy),
    .addrunit_lbuffer_en_in(en_in), .addrunit_lbuffer_addr_in(addr_in),
    .addrunit_lbuffer_dest_in(dest_in), .addrunit_lbuffer_op_in(op_in),
    .lbuffer_mem_en_out(mem_en), .lbuffer_mem_addr_out(mem_addr),
    .lbuffer_mem_size_out(mem_size),
    .mem_lbuffer_done_in(done), .mem_lbuffer_data_in(data),
    .rob_lbuffer_rst_in(flush),
    .cdb_lbuffer_b_out(cdb_b), .cdb_lbuffer_result_out(cdb_res),
    .lbuffer_overflow_out(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] d);
    case (op)
      LB:      return 32'(int'($signed(d[7:0])));
      LH:      return 32'(int'($signed(d[15:0])));
      LBU:     return 32'(d[7:0]);
      LHU:     return 32'(d[15:0]);
      default: return d;
    endcase
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] op);
    if (op == LB || op == LBU) return 3'd1;
    if (op == LH || op == LHU) return 3'd2;
    return 3'd4;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_wait = 0; m_sq = 0; m_ovf = 0; m_b = '0; m_res = '0;
  endfunction

  // Advance one clock edge with the currently driven inputs, then check all outputs.
  task automatic step();
    bit full;
    ld_t e;
    @(posedge clk);
    if (rst_n && rdy) begin
      full = (q.size() == 4);
      m_b = '0;
      if (flush) begin
        if (m_wait) begin
          if (done) begin m_wait = 0; m_sq = 0; end
          else m_sq = 1;
        end
        q.delete();
      end else begin
        if (m_wait) begin
          if (done) begin
            if (!m_sq) begin
              m_b = m_req.dest;
              m_res = ext(m_req.op, data);
              void'(q.pop_front());
            end
            m_sq = 0;
            m_wait = 0;
          end
        end else if (q.size() > 0) begin
          m_wait = 1;
          m_req = q[0];
        end
        if (en_in && !full) begin
          e.addr = addr_in; e.dest = dest_in; e.op = op_in;
          q.push_back(e);
        end
      end
      if (en_in && full) m_ovf = 1;
    end
    #1;
    chk("mem_en", 32'(mem_en), 32'(m_wait));
    if (m_wait) begin
      chk("mem_addr", mem_addr, m_req.addr);
      chk("mem_size", 32'(mem_size), 32'(size_of(m_req.op)));
    end
    chk("cdb_b", 32'(cdb_b), 32'(m_b));
    if (m_b != 0) chk("cdb_result", cdb_res, m_res);
    chk("rs_rdy", 32'(rs_rdy), 32'((4 - q.size()) >= 2));
    chk("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic enq(input logic [2:0] op, input logic [31:0] a, input logic [3:0] d);
    en_in = 1; op_in = op; addr_in = a; dest_in = d;
    step();
    en_in = 0;
  endtask

  task automatic wait_en();
    for (int i = 0; i < 8 && !mem_en; i++) step();
    chk("wait_en", 32'(mem_en), 32'd1);
  endtask

  task automatic finish_load(input logic [31:0] d, input logic [3:0] dest, input logic [31:0] exp);
    wait_en();
    step();
    done = 1; data = d;
    step();
    done = 0;
    chk("dir_b", 32'(cdb_b), 32'(dest));
    chk("dir_res", cdb_res, exp);
    step();
    chk("dir_b_clear", 32'(cdb_b), 32'd0);
  endtask

  logic [3:0] order[$];

  initial begin
    model_reset();
    #12;
    chk("rst_rdy", 32'(rs_rdy), 32'd1);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_b", 32'(cdb_b), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    enq(LB,  32'h100, 4'd3); finish_load(32'h000000F0, 4'd3, 32'hFFFFFFF0);
    enq(LBU, 32'h100, 4'd3); finish_load(32'h000000F0, 4'd3, 32'h000000F0);
    enq(LH,  32'h104, 4'd4); finish_load(32'h12348001, 4'd4, 32'hFFFF8001);
    enq(LHU, 32'h104, 4'd5); finish_load(32'h12348001, 4'd5, 32'h00008001);
    enq(LW,  32'h108, 4'd6); finish_load(32'h12348001, 4'd6, 32'h12348001);

    // Fill with done held low, then a fifth enqueue overflows.
    for (int i = 1; i <= 4; i++) enq(3'(i % 5), 32'h200 + 32'(4*i), 4'(i));
    chk("fill_rdy", 32'(rs_rdy), 32'd0);
    enq(LW, 32'h300, 4'd9);
    chk("fill_ovf", 32'(ovf), 32'd1);
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      done = mem_en && ($urandom_range(0, 2) == 0);
      data = $urandom;
      step();
      if (cdb_b != 0) order.push_back(cdb_b);
    end
    done = 0;
    chk("fill_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("fill_order", 32'(order[i]), 32'(i + 1));

    // Flush in WAIT with two queued; a new load arrives before the stale done.
    enq(LW, 32'h400, 4'd5);
    enq(LW, 32'h404, 4'd6);
    wait_en();
    flush = 1; step(); flush = 0;
    enq(LHU, 32'h500, 4'd7);
    step();
    chk("sq_en_held", 32'(mem_en), 32'd1);
    chk("sq_addr_held", mem_addr, 32'h400);
    done = 1; data = 32'hABCD0123; step(); done = 0;
    chk("sq_no_bcast", 32'(cdb_b), 32'd0);
    finish_load(32'h0000BEEF, 4'd7, 32'h0000BEEF);

    // done and flush on the same edge.
    enq(LB, 32'h600, 4'd8);
    wait_en();
    done = 1; flush = 1; data = 32'h80; step(); done = 0; flush = 0;
    chk("coinc_b", 32'(cdb_b), 32'd0);
    enq(LB, 32'h604, 4'd9);
    finish_load(32'h00000080, 4'd9, 32'hFFFFFF80);

    // Asynchronous reset while a request is outstanding.
    enq(LW, 32'h700, 4'd2);
    wait_en();
    #2 rst_n = 0;
    #1;
    chk("arst_en", 32'(mem_en), 32'd0);
    chk("arst_b", 32'(cdb_b), 32'd0);
    chk("arst_rdy", 32'(rs_rdy), 32'd1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;

    for (int c = 0; c < 2000; c++) begin
      en_in   = ($urandom_range(0, 9) < 4) && (rs_rdy || $urandom_range(0, 7) == 0);
      op_in   = 3'($urandom_range(0, 4));
      addr_in = $urandom;
      dest_in = 4'($urandom_range(1, 15));
      done    = mem_en && ($urandom_range(0, 3) == 0);
      data    = $urandom;
      flush   = ($urandom_range(0, 24) == 0);
      rdy     = ($urandom_range(0, 15) != 0);
      step();
    end
    en_in = 0; done = 0; flush = 0; rdy = 1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
